counter_share_ctrl: RTL and testbench

- Sequencer and round-robin arbiter that shares one 4-bit up-counter datapath (sync active-high clear, active-high increment enable) between NUM_REQ requesters.
- Each granted requester gets one counting "job": the controller clears the counter, enables it until it reaches that requester's programmed length, then pulses done.
- Sits between the requesters and the shared counter. It drives the counter's clear and enable inputs and monitors its count value.

---
 rtl/counter_share_ctrl.sv | 147 ++++++++++++++
 tb/tb_counter_share_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_share_ctrl.sv
// counter_share_ctrl: round-robin sequencer sharing one up-counter between NUM_REQ requesters.
// Revision 1.0 - initial release
`default_nettype none

module counter_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] len,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     cnt_clr,
  output logic                     cnt_en,
  input  logic [CNT_W-1:0]         cnt_value,
  output logic                     wd_err
);

  localparam int                 IDX_W     = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]   LAST_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W:0]     WD_LAST   = {1'b1, {CNT_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic               cnt_clr_q;
  logic               wd_err_q;
  logic [IDX_W-1:0]   last_q;
  logic [IDX_W-1:0]   win_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W:0]     wd_q;
  logic [CNT_W:0]     wd_d;

  logic [CNT_W-1:0]   len_arr [NUM_REQ];
  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   cand;
  logic               req_win;
  logic               match;
  logic               wd_hit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_len
    assign len_arr[gi] = len[gi*CNT_W +: CNT_W];
  end

  // Scan from farthest to nearest so the requester closest after last_q wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign req_win = req[win_q];
  assign match   = (cnt_value == len_q);
  assign wd_d    = wd_q + 1'b1;
  // wd_q counts completed RUN cycles; hitting WD_LAST means this is the last allowed one.
  assign wd_hit  = (wd_q == WD_LAST) && !match;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      cnt_clr_q <= 1'b1;
      wd_err_q  <= 1'b0;
      last_q    <= LAST_INIT;
      win_q     <= '0;
      len_q     <= '0;
      wd_q      <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          cnt_clr_q <= arb_found;
          if (arb_found) begin
            state_q <= ST_CLEAR;
            gnt_q   <= NUM_REQ'(1) << arb_idx;
            win_q   <= arb_idx;
            last_q  <= arb_idx;
            len_q   <= len_arr[arb_idx];
          end
        end
        ST_CLEAR: begin
          cnt_clr_q <= 1'b0;
          wd_q      <= '0;
          if (!req_win) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          wd_q <= wd_d;
          if (!req_win) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            if (wd_hit) wd_err_q <= 1'b1;
          end else if (match) begin
            state_q <= ST_DONE;
            done_q  <= gnt_q;
          end else if (wd_hit) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            wd_err_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
        default: begin
          state_q   <= ST_IDLE;
          gnt_q     <= '0;
          cnt_clr_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign busy    = (state_q != ST_IDLE);
  assign cnt_clr = cnt_clr_q;
  assign cnt_en  = (state_q == ST_RUN) && req_win && !match;
  assign wd_err  = wd_err_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_share_ctrl.sv
// tb_counter_share_ctrl: directed scenarios plus random traffic against a cycle-timeline reference model.
`default_nettype none

module tb_counter_share_ctrl;
  localparam int NR = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req;
  logic [NR*CW-1:0] len;
  logic [NR-1:0]   gnt, done;
  logic            busy, cnt_clr, cnt_en, wd_err;
  logic [CW-1:0]   cnt_value = '0;
  logic            stuck;

  int checks = 0;
  int failures = 0;

  counter_share_ctrl #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .len(len), .gnt(gnt), .done(done),
    .busy(busy), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_value(cnt_value), .wd_err(wd_err)
  );

  always #5 clk = ~clk;

  // Shared counter: ideal up-counter, or stuck at zero when 'stuck' is set.
  always @(posedge clk) begin
    if (cnt_clr || stuck) cnt_value <= '0;
    else if (cnt_en)      cnt_value <= cnt_value + 1'b1;
  end

  // Reference model: a job is described by its owner, frozen length and age.
  bit m_job, m_fin, m_rclr, m_wd;
  int m_own, m_len, m_t, m_last;
  logic [NR-1:0] ed_last;
  logic [NR-1:0] prev_gnt = '0;
  int n_gnt [NR];
  int n_done [NR];
  int n_en;
  int order_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_job = 0; m_fin = 0; m_wd = 0; m_rclr = 1; m_last = NR - 1; m_own = 0; m_len = 0; m_t = 0;
  endtask

  task automatic clr_stats();
    for (int i = 0; i < NR; i++) begin n_gnt[i] = 0; n_done[i] = 0; end
    n_en = 0;
    order_q.delete();
  endtask

  task automatic step();
    logic [NR-1:0] e_gnt, e_done, rq;
    logic [NR*CW-1:0] ln;
    logic e_clr, e_en, rs;
    int cv;
    @(negedge clk);
    rq = req; ln = len; rs = reset; cv = int'(cnt_value);
    e_gnt  = m_job ? NR'(1 << m_own) : '0;
    e_done = m_fin ? NR'(1 << m_own) : '0;
    e_clr  = m_job ? (m_t == 0 && !m_fin) : m_rclr;
    e_en   = m_job && !m_fin && m_t >= 1 && rq[m_own] && (cv != m_len);
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("done", 32'(done), 32'(e_done));
    chk("busy", 32'(busy), 32'(m_job));
    chk("cnt_clr", 32'(cnt_clr), 32'(e_clr));
    chk("cnt_en", 32'(cnt_en), 32'(e_en));
    chk("wd_err", 32'(wd_err), 32'(m_wd));
    chk("inv_onehot", 32'($countones(gnt) <= 1), 32'(1));
    chk("inv_done_gnt", 32'((done & ~gnt) == '0), 32'(1));
    chk("inv_en_clr", 32'(!(cnt_en && cnt_clr)), 32'(1));
    ed_last = e_done;
    if (cnt_en) n_en++;
    for (int i = 0; i < NR; i++) begin
      if (gnt[i]) n_gnt[i]++;
      if (done[i]) n_done[i]++;
      if (gnt[i] && !prev_gnt[i]) order_q.push_back(i);
    end
    prev_gnt = gnt;
    // Advance the model to the state after the coming edge.
    if (!rs) model_reset();
    else if (!m_job) begin
      m_rclr = 0;
      for (int k = 1; k <= NR; k++) begin
        if (!m_job && rq[(m_last + k) % NR]) begin
          m_job = 1; m_fin = 0; m_t = 0;
          m_own = (m_last + k) % NR;
          m_len = int'(ln[m_own*CW +: CW]);
          m_last = m_own;
        end
      end
    end
    else if (m_fin) begin m_job = 0; m_fin = 0; end
    else if (!rq[m_own]) begin
      if (m_t == (1 << CW) + 1 && cv != m_len) m_wd = 1;
      m_job = 0;
    end
    else if (m_t == 0) m_t = 1;
    else if (cv == m_len) m_fin = 1;
    else if (m_t == (1 << CW) + 1) begin m_wd = 1; m_job = 0; end
    else m_t++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit autodrop);
    for (int c = 0; c < n; c++) begin
      step();
      if (autodrop) req = req & ~ed_last;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; stuck = 1'b0;
    run(2, 1'b0);
    reset = 1'b1;
  endtask

  function automatic int ord(input int i);
    return (order_q.size() > i) ? order_q[i] : 99;
  endfunction

  initial begin
    reset = 1'b0; req = '0; len = '0; stuck = 1'b0;
    model_reset();
    clr_stats();
    repeat (2) @(posedge clk);
    #1;
    run(2, 1'b0);
    reset = 1'b1;

    // Single job, len 5
    clr_stats();
    req = 4'b0001; len[0 +: CW] = 4'd5;
    run(12, 1'b1);
    chk("single_gnt_cycles", 32'(n_gnt[0]), 32'd8);
    chk("single_en_cycles", 32'(n_en), 32'd5);
    chk("single_done", 32'(n_done[0]), 32'd1);
    chk("single_busy_after", 32'(busy), 32'd0);

    // Zero length
    clr_stats();
    req = 4'b0010; len[CW +: CW] = 4'd0;
    run(6, 1'b1);
    chk("zero_gnt_cycles", 32'(n_gnt[1]), 32'd3);
    chk("zero_en_cycles", 32'(n_en), 32'd0);
    chk("zero_done", 32'(n_done[1]), 32'd1);

    // Round robin with all requesters held
    do_reset();
    clr_stats();
    req = 4'b1111; len = {4'd2, 4'd2, 4'd2, 4'd2};
    run(30, 1'b0);
    chk("rr_0", 32'(ord(0)), 32'd0);
    chk("rr_1", 32'(ord(1)), 32'd1);
    chk("rr_2", 32'(ord(2)), 32'd2);
    chk("rr_3", 32'(ord(3)), 32'd3);
    chk("rr_4", 32'(ord(4)), 32'd0);
    chk("rr_window", 32'(n_gnt[1]), 32'd5);

    // Abort after 3 RUN cycles
    do_reset();
    clr_stats();
    len[2*CW +: CW] = 4'd9; len[3*CW +: CW] = 4'd1;
    req = 4'b1100;
    run(5, 1'b0);
    req[2] = 1'b0;
    run(1, 1'b0);
    chk("abort_en_cycles", 32'(n_en), 32'd3);
    run(8, 1'b1);
    chk("abort_first", 32'(ord(0)), 32'd2);
    chk("abort_next", 32'(ord(1)), 32'd3);
    chk("abort_no_done", 32'(n_done[2]), 32'd0);
    chk("abort_next_done", 32'(n_done[3]), 32'd1);

    // Watchdog with a stuck counter
    do_reset();
    clr_stats();
    stuck = 1'b1; len[0 +: CW] = 4'd7; req = 4'b0001;
    run(21, 1'b0);
    chk("wd_en_cycles", 32'(n_en), 32'd17);
    chk("wd_flag", 32'(wd_err), 32'd1);
    chk("wd_no_done", 32'(n_done[0]), 32'd0);
    req = '0; stuck = 1'b0;
    run(3, 1'b1);
    clr_stats();
    req = 4'b0010; len[CW +: CW] = 4'd3;
    run(10, 1'b1);
    chk("wd_next_done", 32'(n_done[1]), 32'd1);
    chk("wd_sticky", 32'(wd_err), 32'd1);

    // Reset in the middle of RUN
    req = 4'b0100; len[2*CW +: CW] = 4'd6;
    run(4, 1'b0);
    reset = 1'b0;
    run(1, 1'b0);
    reset = 1'b1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clr", 32'(cnt_clr), 32'd1);
    chk("rst_wd", 32'(wd_err), 32'd0);
    clr_stats();
    req = 4'b1111; len = {4'd1, 4'd1, 4'd1, 4'd1};
    run(4, 1'b0);
    chk("rst_prio", 32'(ord(0)), 32'd0);

    // Random traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < NR; i++) begin
        if (ed_last[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            len[i*CW +: CW] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(0, 4));
          end
        end else if (m_job && m_own == i && !m_fin && $urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
        if (m_job && m_own == i && $urandom_range(0, 9) == 0) len[i*CW +: CW] = 4'($urandom);
      end
      if (!m_job && $urandom_range(0, 49) == 0) stuck = !stuck;
      reset = ($urandom_range(0, 199) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
